// File: rtl/ahb_bus_arbiter_if.sv
// ahb_bus_arbiter_if: the arbitration signals shared by the AHB masters and the arbiter.
//   HBUSREQ   per-master bus request
//   HLOCK     per-master locked-transfer request
//   HTRANS    transfer type of the current address phase
//   HBURST    burst type of the current address phase
//   HREADY    shared transfer-complete indication
//   HGRANT    one-hot grant (driven by the arbiter)
//   HMASTER   index of the current address-phase owner (driven by the arbiter)
//   HMASTLOCK current address phase is locked (driven by the arbiter)
// Modports: slave = arbiter side, master = requester/bench side.
interface ahb_bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2
);
  localparam int unsigned IdxW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [IdxW-1:0]        HMASTER;
  logic                   HMASTLOCK;

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    output HGRANT, HMASTER, HMASTLOCK
  );

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    input  HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: AHB bus arbiter with burst and locked-transfer hold.
//   HCLK     clock, all state changes on the rising edge
//   HRESETn  synchronous active-low reset
//   bus      ahb_bus_arbiter_if.slave: requests/locks/transfer info in, grant/owner/lock out
// Grant only moves on HREADY=1 edges. Fixed 4/8/16-beat bursts and locked sequences hold the
// grant; everything else re-arbitrates every transfer.
// Build option: define AHB_ARB_ROUND_ROBIN_EN for round-robin arbitration (winner is the first
// requester after the last granted index); otherwise fixed priority, lowest index wins.
module ahb_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_bus_arbiter_if.slave bus
);
  localparam int unsigned IdxW = $clog2(NUM_MASTERS);

  localparam logic [1:0] TransBusy   = 2'b01;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  typedef enum logic [1:0] {StArb, StBurst, StLocked} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IdxW-1:0]        hmaster_q, hmaster_d;
  logic                   mlock_q, mlock_d;

  logic [IdxW-1:0]        g_idx;
  logic                   g_lock;
  logic [IdxW-1:0]        win_idx;
  logic [NUM_MASTERS-1:0] win_oh;
  logic [3:0]             burst_len;

  // Index and lock request of the currently granted master.
  always_comb begin
    g_idx  = '0;
    g_lock = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        g_idx  = IdxW'(i);
        g_lock = bus.HLOCK[i];
      end
    end
  end

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic [IdxW-1:0] ptr_q, ptr_d;
  int unsigned     dist, best_dist;

  // Distance upward from the pointer; the pointer's own slot is scanned last.
  always_comb begin
    win_idx   = IdxW'(DEFAULT_MASTER);
    best_dist = NUM_MASTERS + 1;
    dist      = 0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      dist = (i + NUM_MASTERS - 32'(ptr_q)) % NUM_MASTERS;
      if (dist == 0) dist = NUM_MASTERS;
      if (bus.HBUSREQ[i] && (dist < best_dist)) begin
        best_dist = dist;
        win_idx   = IdxW'(i);
      end
    end
  end

  // Grant only ever moves to win_idx, so a changed grant means the pointer follows it.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_d != grant_q) ptr_d = win_idx;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) ptr_q <= IdxW'(DEFAULT_MASTER);
    else          ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win_idx = IdxW'(DEFAULT_MASTER);
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (bus.HBUSREQ[i]) win_idx = IdxW'(i);
    end
  end
`endif

  assign win_oh = NUM_MASTERS'(1) << win_idx;

  // Remaining SEQ beats after the NONSEQ of a fixed-length burst; 0 = no burst hold.
  always_comb begin
    unique case (bus.HBURST)
      3'd2, 3'd3: burst_len = 4'd3;
      3'd4, 3'd5: burst_len = 4'd7;
      3'd6, 3'd7: burst_len = 4'd15;
      default:    burst_len = 4'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    hmaster_d = hmaster_q;
    mlock_d   = mlock_q;
    if (bus.HREADY) begin
      hmaster_d = g_idx;
      mlock_d   = g_lock;
      case (state_q)
        StArb: begin
          cnt_d = '0;
          if (g_lock) begin
            state_d = StLocked;
          end else if ((bus.HTRANS == TransNonseq) && (burst_len != 4'd0)) begin
            state_d = StBurst;
            cnt_d   = burst_len;
          end else begin
            grant_d = win_oh;
          end
        end
        StBurst: begin
          if (g_lock) begin
            state_d = StLocked;
            cnt_d   = '0;
          end else if (bus.HTRANS == TransSeq) begin
            cnt_d = cnt_q - 4'd1;
            // Leaving at count 1 lets the next owner be granted during the last beat.
            if (cnt_q == 4'd2) begin
              state_d = StArb;
              grant_d = win_oh;
            end
          end else if (bus.HTRANS != TransBusy) begin
            // IDLE or NONSEQ: burst ended early.
            state_d = StArb;
            cnt_d   = '0;
            grant_d = win_oh;
          end
        end
        StLocked: begin
          // HTRANS[0]=0 covers IDLE and NONSEQ.
          if (!g_lock && !bus.HTRANS[0]) begin
            state_d = StArb;
            grant_d = win_oh;
          end
        end
        default: state_d = StArb;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q   <= StArb;
      cnt_q     <= '0;
      grant_q   <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      hmaster_q <= IdxW'(DEFAULT_MASTER);
      mlock_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      hmaster_q <= hmaster_d;
      mlock_q   <= mlock_d;
    end
  end

  assign bus.HGRANT    = grant_q;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = mlock_q;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: vector table, directed burst/lock/reset sequences and a randomized run
// against a behavioural model of the arbitration rules.
module tb_ahb_bus_arbiter;
  localparam int NM   = 2;
  localparam int DefM = 0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif
  localparam logic [1:0] Idle = 2'd0, Busy = 2'd1, Nonseq = 2'd2, Seq = 2'd3;
  localparam logic [2:0] Single = 3'd0, Incr4 = 3'd3, Incr8 = 3'd5, Incr16 = 3'd7;
  localparam int ModeArb = 0, ModeBurst = 1, ModeLocked = 2;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  ahb_bus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

  ahb_bus_arbiter #(.NUM_MASTERS(NM), .DEFAULT_MASTER(DefM)) dut (
    .HCLK   (clk),
    .HRESETn(rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: owner index, mode and remaining beats as plain integers.
  int m_g, m_owner, m_mode, m_left;
  bit m_mlock;

  function automatic int pick(input logic [NM-1:0] req);
    int w;
    w = DefM;
`ifdef AHB_ARB_ROUND_ROBIN_EN
    for (int k = NM; k >= 1; k--) if (((req >> ((m_g + k) % NM)) & NM'(1)) != '0) w = (m_g + k) % NM;
`else
    for (int i = NM - 1; i >= 0; i--) if (((req >> i) & NM'(1)) != '0) w = i;
`endif
    return w;
  endfunction

  task automatic model_step(input logic r, input logic [NM-1:0] req, input logic [NM-1:0] lk,
                            input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    bit own_lock;
    if (!r) begin
      m_g = DefM; m_owner = DefM; m_mlock = 1'b0; m_mode = ModeArb; m_left = 0;
      return;
    end
    if (!rdy) return;
    own_lock = ((lk >> m_g) & NM'(1)) != '0;
    m_owner  = m_g;
    m_mlock  = own_lock;
    case (m_mode)
      ModeArb: begin
        m_left = 0;
        if (own_lock) m_mode = ModeLocked;
        else if (tr == Nonseq && bu >= 3'd2) begin
          m_mode = ModeBurst;
          m_left = (4 << ((int'(bu) - 2) / 2)) - 1;  // beats after the NONSEQ
        end else m_g = pick(req);
      end
      ModeBurst: begin
        if (own_lock) begin m_mode = ModeLocked; m_left = 0; end
        else if (tr == Seq) begin
          m_left--;
          if (m_left == 1) begin m_mode = ModeArb; m_g = pick(req); end
        end else if (tr != Busy) begin m_mode = ModeArb; m_left = 0; m_g = pick(req); end
      end
      default: begin
        if (!own_lock && (tr == Idle || tr == Nonseq)) begin m_mode = ModeArb; m_g = pick(req); end
      end
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [NM-1:0] req, input logic [NM-1:0] lk,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    rstn = r; bus.HBUSREQ = req; bus.HLOCK = lk; bus.HTRANS = tr; bus.HBURST = bu;
    bus.HREADY = rdy;
    @(posedge clk);
    model_step(r, req, lk, tr, bu, rdy);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [NM-1:0] g, input int m, input bit ml);
    check({name, "_grant"}, 32'(bus.HGRANT), 32'(g));
    check({name, "_master"}, 32'(bus.HMASTER), 32'(m));
    check({name, "_mastlock"}, 32'(bus.HMASTLOCK), 32'(ml));
  endtask

  typedef struct {
    logic          rstn;
    logic [NM-1:0] req;
    logic [NM-1:0] lk;
    logic [1:0]    tr;
    logic [2:0]    bu;
    logic          rdy;
    logic [NM-1:0] g_fp;
    logic [NM-1:0] g_rr;
    int            m_fp;
    int            m_rr;
    bit            ml;
  } vec_t;

  vec_t tbl[9];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn = 1'b0;
    bus.HBUSREQ = '0; bus.HLOCK = '0; bus.HTRANS = Idle; bus.HBURST = Single; bus.HREADY = 1'b1;

    // Reset, idle default, contention, wait state, single requester, release.
    tbl[0] = '{1'b0, 2'b00, 2'b00, Idle,   Single, 1'b1, 2'b01, 2'b01, 0, 0, 1'b0};
    tbl[1] = '{1'b1, 2'b00, 2'b00, Idle,   Single, 1'b1, 2'b01, 2'b01, 0, 0, 1'b0};
    tbl[2] = '{1'b1, 2'b11, 2'b00, Nonseq, Single, 1'b1, 2'b01, 2'b10, 0, 0, 1'b0};
    tbl[3] = '{1'b1, 2'b11, 2'b00, Nonseq, Single, 1'b1, 2'b01, 2'b01, 0, 1, 1'b0};
    tbl[4] = '{1'b1, 2'b11, 2'b00, Nonseq, Single, 1'b1, 2'b01, 2'b10, 0, 0, 1'b0};
    tbl[5] = '{1'b1, 2'b11, 2'b00, Nonseq, Single, 1'b0, 2'b01, 2'b10, 0, 0, 1'b0};
    tbl[6] = '{1'b1, 2'b10, 2'b00, Nonseq, Single, 1'b1, 2'b10, 2'b10, 0, 1, 1'b0};
    tbl[7] = '{1'b1, 2'b00, 2'b00, Idle,   Single, 1'b1, 2'b01, 2'b01, 1, 1, 1'b0};
    tbl[8] = '{1'b1, 2'b01, 2'b00, Idle,   Single, 1'b1, 2'b01, 2'b01, 0, 0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].rstn, tbl[i].req, tbl[i].lk, tbl[i].tr, tbl[i].bu, tbl[i].rdy);
      expect_out($sformatf("vec%0d", i), Rr ? tbl[i].g_rr : tbl[i].g_fp,
                 Rr ? tbl[i].m_rr : tbl[i].m_fp, tbl[i].ml);
    end
    check("vec_cnt", 32'(dut.cnt_q), 32'd0);

    // INCR4 by M1 while M0 requests: grant re-arbitrates when the count reaches 1.
    drive(1, 2'b10, 2'b00, Idle, Single, 1);
    check("incr4_pre_grant", 32'(bus.HGRANT), 32'b10);
    drive(1, 2'b11, 2'b00, Nonseq, Incr4, 1);
    check("incr4_nonseq_grant", 32'(bus.HGRANT), 32'b10);
    check("incr4_nonseq_cnt", 32'(dut.cnt_q), 32'd3);
    drive(1, 2'b11, 2'b00, Seq, Incr4, 1);
    check("incr4_seq1_grant", 32'(bus.HGRANT), 32'b10);
    check("incr4_seq1_cnt", 32'(dut.cnt_q), 32'd2);
    drive(1, 2'b11, 2'b00, Seq, Incr4, 1);
    expect_out("incr4_seq2", 2'b01, 1, 1'b0);
    check("incr4_seq2_cnt", 32'(dut.cnt_q), 32'd1);
    drive(1, 2'b01, 2'b00, Seq, Incr4, 1);
    expect_out("incr4_last", 2'b01, 0, 1'b0);
    check("incr4_last_cnt", 32'(dut.cnt_q), 32'd0);

    // INCR8 with five wait states mid-burst, then BUSY which must not count.
    drive(1, 2'b10, 2'b00, Idle, Single, 1);
    drive(1, 2'b11, 2'b00, Nonseq, Incr8, 1);
    check("incr8_cnt0", 32'(dut.cnt_q), 32'd7);
    for (int b = 0; b < 2; b++) drive(1, 2'b11, 2'b00, Seq, Incr8, 1);
    check("incr8_cnt2", 32'(dut.cnt_q), 32'd5);
    for (int w = 0; w < 5; w++) begin
      drive(1, 2'b11, 2'b00, Seq, Incr8, 0);
      expect_out($sformatf("incr8_wait%0d", w), 2'b10, 1, 1'b0);
      check($sformatf("incr8_wait%0d_cnt", w), 32'(dut.cnt_q), 32'd5);
    end
    drive(1, 2'b11, 2'b00, Busy, Incr8, 1);
    check("incr8_busy_cnt", 32'(dut.cnt_q), 32'd5);
    for (int b = 0; b < 4; b++) begin
      drive(1, 2'b11, 2'b00, Seq, Incr8, 1);
      check($sformatf("incr8_beat%0d_cnt", b + 3), 32'(dut.cnt_q), 32'(4 - b));
      check($sformatf("incr8_beat%0d_grant", b + 3), 32'(bus.HGRANT), (b == 3) ? 32'b01 : 32'b10);
    end
    drive(1, 2'b01, 2'b00, Seq, Incr8, 1);
    expect_out("incr8_beat7", 2'b01, 0, 1'b0);
    check("incr8_beat7_cnt", 32'(dut.cnt_q), 32'd0);

    // Locked sequence by M0 with both requesting.
    drive(1, 2'b11, 2'b01, Nonseq, Single, 1);
    expect_out("lock_start", 2'b01, 0, 1'b1);
    drive(1, 2'b11, 2'b01, Seq, Single, 1);
    expect_out("lock_hold", 2'b01, 0, 1'b1);
    drive(1, 2'b11, 2'b00, Seq, Single, 1);
    expect_out("lock_drop_seq", 2'b01, 0, 1'b0);
    drive(1, 2'b10, 2'b00, Nonseq, Single, 1);
    expect_out("lock_release", 2'b10, 0, 1'b0);

    // Reset during the second beat of INCR16, then prove ARB by re-arbitrating on SEQ.
    drive(1, 2'b01, 2'b00, Idle, Single, 1);
    drive(1, 2'b01, 2'b00, Nonseq, Incr16, 1);
    check("incr16_cnt", 32'(dut.cnt_q), 32'd15);
    drive(0, 2'b11, 2'b01, Seq, Incr16, 0);
    expect_out("incr16_reset", 2'b01, 0, 1'b0);
    check("incr16_reset_cnt", 32'(dut.cnt_q), 32'd0);
    drive(1, 2'b10, 2'b00, Seq, Incr16, 1);
    check("incr16_after_grant", 32'(bus.HGRANT), 32'b10);
    check("incr16_after_cnt", 32'(dut.cnt_q), 32'd0);

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      logic          r, rdy;
      logic [NM-1:0] req, lk;
      logic [1:0]    tr;
      logic [2:0]    bu;
      r   = ($urandom_range(0, 99) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      req = NM'($urandom);
      lk  = ($urandom_range(0, 7) == 0) ? NM'($urandom) : '0;
      bu  = 3'($urandom);
      if (m_mode == ModeBurst && $urandom_range(0, 9) < 7) tr = Seq;
      else tr = 2'($urandom);
      drive(r, req, lk, tr, bu, rdy);
      check("rnd_grant", 32'(bus.HGRANT), 32'(1) << m_g);
      check("rnd_master", 32'(bus.HMASTER), 32'(m_owner));
      check("rnd_mastlock", 32'(bus.HMASTLOCK), 32'(m_mlock));
      check("rnd_cnt", 32'(dut.cnt_q), 32'(m_left));
      check("rnd_onehot", 32'($onehot(bus.HGRANT)), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
